sram_looper: RTL and testbench

Final stage of the effect chain: takes the delay stage's output sample and records it into a dedicated SRAM region, or plays the stored loop back mixed with the live signal. It also signals when a recording hits maximum length, and its output is the DAC sample. It owns the SRAM bus for the slot between the delay's valid pulse and its own o_valid pulse. All other times it is pass-through.

---
 rtl/sram_looper.sv | 172 +++++++++++++++++
 tb/tb_sram_looper.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_looper.sv
// sram_looper: last effect stage. Records samples into a SRAM loop region or plays the loop back mixed with live audio.
// Build option LOOPER_OVERDUB_EN adds an overdub write-back (WB) step to play slots.
module sram_looper #(
    parameter logic [19:0] LOOP_BASE = 20'h80000,
    parameter logic [19:0] MAX_LEN   = 20'h7FFFF
) (
    input  logic        i_AUD_BCLK,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [15:0] i_data,
    input  logic [2:0]  i_mode,
    input  logic [2:0]  i_level,
    input  logic        i_overdub,
    input  logic [15:0] i_sram_rdata,
    output logic [19:0] o_sram_addr,
    output logic        o_sram_we_n,
    output logic [15:0] o_sram_wdata,
    output logic [15:0] o_data,
    output logic        o_valid,
    output logic        o_record_finish
);

    localparam logic [2:0] MODE_REC  = 3'd3;
    localparam logic [2:0] MODE_PLAY = 3'd4;

`ifdef LOOPER_OVERDUB_EN
    typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_SETTLE, S_WB, S_OUT} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_SETTLE, S_OUT} state_t;
`endif

    state_t      r_state;
    logic [2:0]  r_mode;
    logic [2:0]  r_level;
    logic [15:0] r_live;
    logic        r_play;
    logic        r_finish_pend;
    logic [19:0] r_wr_ptr;
    logic [19:0] r_rd_ptr;
    logic [19:0] r_loop_len;
`ifdef LOOPER_OVERDUB_EN
    logic        r_od;
`else
    logic        w_unused;
    assign w_unused = i_overdub;
`endif

    // Pointer view as it stands once the record/leave-record transition is applied.
    logic [19:0] w_wr_base, w_wr_inc, w_len_eff, w_rd_eff, w_rd_next;
    assign w_wr_base = (r_mode == MODE_REC) ? r_wr_ptr : 20'd0;
    assign w_wr_inc  = w_wr_base + 20'd1;
    assign w_len_eff = (r_mode == MODE_REC) ? r_wr_ptr : r_loop_len;
    assign w_rd_eff  = (r_mode == MODE_REC) ? 20'd0 : r_rd_ptr;
    assign w_rd_next = (w_rd_eff == w_len_eff - 20'd1) ? 20'd0 : w_rd_eff + 20'd1;

    logic [3:0]         w_gain;
    logic signed [20:0] w_loop_ext, w_gain_ext, w_prod;
    logic signed [16:0] w_scaled, w_sum;
    logic [15:0]        w_mix;
    assign w_gain     = 4'd8 - {1'b0, r_level};
    assign w_loop_ext = {{5{i_sram_rdata[15]}}, i_sram_rdata};
    assign w_gain_ext = {17'd0, w_gain};
    assign w_prod     = w_loop_ext * w_gain_ext;
    assign w_scaled   = 17'(w_prod >>> 3);
    assign w_sum      = {r_live[15], r_live} + w_scaled;
    // A 17-bit result whose top two bits disagree no longer fits in 16 bits.
    assign w_mix      = (w_sum[16] != w_sum[15]) ? (w_sum[16] ? 16'h8000 : 16'h7FFF) : w_sum[15:0];

    always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= S_IDLE;
            r_mode          <= 3'd0;
            r_level         <= 3'd0;
            r_live          <= 16'd0;
            r_play          <= 1'b0;
            r_finish_pend   <= 1'b0;
            r_wr_ptr        <= 20'd0;
            r_rd_ptr        <= 20'd0;
            r_loop_len      <= 20'd0;
`ifdef LOOPER_OVERDUB_EN
            r_od            <= 1'b0;
`endif
            o_sram_addr     <= 20'd0;
            o_sram_we_n     <= 1'b1;
            o_sram_wdata    <= 16'd0;
            o_data          <= 16'd0;
            o_valid         <= 1'b0;
            o_record_finish <= 1'b0;
        end else begin
            o_valid         <= 1'b0;
            o_record_finish <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_live        <= i_data;
                        r_level       <= i_level;
                        r_mode        <= i_mode;
                        r_play        <= 1'b0;
                        r_finish_pend <= 1'b0;
`ifdef LOOPER_OVERDUB_EN
                        r_od          <= i_overdub;
`endif
                        r_state       <= S_ACCESS;
                        if (i_mode == MODE_REC) begin
                            if (r_mode != MODE_REC) begin
                                r_loop_len <= 20'd0;
                            end
                            if (w_wr_base < MAX_LEN) begin
                                o_sram_addr   <= LOOP_BASE + w_wr_base;
                                o_sram_we_n   <= 1'b0;
                                o_sram_wdata  <= i_data;
                                r_wr_ptr      <= w_wr_inc;
                                r_finish_pend <= (w_wr_inc == MAX_LEN);
                            end else begin
                                r_wr_ptr <= w_wr_base;
                            end
                        end else begin
                            if (r_mode == MODE_REC) begin
                                r_loop_len <= r_wr_ptr;
                                r_rd_ptr   <= 20'd0;
                            end
                            if (i_mode == MODE_PLAY && w_len_eff != 20'd0) begin
                                o_sram_addr <= LOOP_BASE + w_rd_eff;
                                r_play      <= 1'b1;
                                r_rd_ptr    <= w_rd_next;
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    o_sram_we_n     <= 1'b1;
                    o_sram_wdata    <= 16'd0;
                    o_data          <= r_play ? w_mix : r_live;
                    o_valid         <= 1'b1;
                    o_record_finish <= r_finish_pend;
                    r_state         <= S_OUT;
`ifdef LOOPER_OVERDUB_EN
                    // Overdub: write the mix back first; o_data only changes with o_valid.
                    if (r_play && r_od) begin
                        o_sram_we_n     <= 1'b0;
                        o_sram_wdata    <= w_mix;
                        o_data          <= o_data;
                        o_valid         <= 1'b0;
                        o_record_finish <= 1'b0;
                        r_state         <= S_WB;
                    end
`endif
                end
`ifdef LOOPER_OVERDUB_EN
                S_WB: begin
                    o_sram_we_n  <= 1'b1;
                    o_sram_wdata <= 16'd0;
                    o_data       <= o_sram_wdata;
                    o_valid      <= 1'b1;
                    r_state      <= S_OUT;
                end
`endif
                S_OUT: begin
                    o_sram_addr <= 20'd0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_looper.sv
// tb_sram_looper: scoreboard bench for sram_looper with a small SRAM model; MAX_LEN is overridden to 4.
module tb_sram_looper;

    localparam logic [19:0] BASE = 20'h80000;
    localparam logic [19:0] MAXL = 20'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [15:0] i_data = '0;
    logic [2:0]  i_mode = '0;
    logic [2:0]  i_level = '0;
    logic        i_overdub = 1'b0;
    logic [15:0] sram_rdata;
    logic [19:0] sram_addr;
    logic        sram_we_n;
    logic [15:0] sram_wdata;
    logic [15:0] o_data;
    logic        o_valid;
    logic        o_record_finish;

    sram_looper #(.LOOP_BASE(BASE), .MAX_LEN(MAXL)) dut (
        .i_AUD_BCLK     (clk),
        .i_rst_n        (rst_n),
        .i_valid        (i_valid),
        .i_data         (i_data),
        .i_mode         (i_mode),
        .i_level        (i_level),
        .i_overdub      (i_overdub),
        .i_sram_rdata   (sram_rdata),
        .o_sram_addr    (sram_addr),
        .o_sram_we_n    (sram_we_n),
        .o_sram_wdata   (sram_wdata),
        .o_data         (o_data),
        .o_valid        (o_valid),
        .o_record_finish(o_record_finish)
    );

    always #5 clk = ~clk;

    // Asynchronous-read SRAM model, low address bits only
    logic [15:0] sram [16];
    always_comb sram_rdata = sram[sram_addr[3:0]];
    always @(posedge clk) if (!sram_we_n) sram[sram_addr[3:0]] <= sram_wdata;

    typedef struct {
        logic [15:0] data;
        logic        fin;
        int          lat;
        int          wcnt;
        int          wcyc;
        logic [19:0] waddr;
        logic [15:0] wdata;
        logic        chk_raddr;
        logic [19:0] raddr;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model state
    logic [2:0]  m_prev = 3'd0;
    int          m_wr = 0, m_len = 0, m_rd = 0;
    logic [15:0] exp_mem [16];

    function automatic logic [15:0] mix(input logic [15:0] live, input logic [15:0] loopv, input logic [2:0] lvl);
        int p, s;
        p = int'($signed(loopv)) * (8 - int'(lvl));
        p = p >>> 3;
        s = int'($signed(live)) + p;
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return 16'(s);
    endfunction

    // Monitor: one line per completed slot
    int          cyc = 0, wcnt = 0, wcyc = 0;
    bit          active = 0, post = 0;
    logic [19:0] m_raddr, m_waddr;
    logic [15:0] m_wd;
    exp_t        e;

    always @(negedge clk) begin
        if (!rst_n) begin
            active = 0;
            post = 0;
        end else begin
            if (post) begin
                check("idle_addr", 32'(sram_addr), 32'd0);
                check("idle_we_n", 32'(sram_we_n), 32'd1);
                check("idle_wdata", 32'(sram_wdata), 32'd0);
                post = 0;
            end
            if (active) begin
                cyc++;
                if (cyc == 1) m_raddr = sram_addr;
                if (!sram_we_n) begin
                    if (wcnt == 0) begin
                        wcyc = cyc;
                        m_waddr = sram_addr;
                        m_wd = sram_wdata;
                    end
                    wcnt++;
                end
                if (o_valid) begin
                    if (sb.size() == 0) begin
                        check("sb_empty", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        $display("slot: o_data=%0h fin=%0b lat=%0d writes=%0d", o_data, o_record_finish, cyc, wcnt);
                        check("o_data", 32'(o_data), 32'(e.data));
                        check("finish", 32'(o_record_finish), 32'(e.fin));
                        check("latency", cyc, e.lat);
                        check("wr_cycles", wcnt, e.wcnt);
                        if (e.wcnt > 0) begin
                            check("wr_addr", 32'(m_waddr), 32'(e.waddr));
                            check("wr_data", 32'(m_wd), 32'(e.wdata));
                            check("wr_first_cyc", wcyc, e.wcyc);
                        end
                        if (e.chk_raddr) check("acc_addr", 32'(m_raddr), 32'(e.raddr));
                    end
                    active = 0;
                    post = 1;
                end else if (o_record_finish) begin
                    check("stray_finish", 32'd1, 32'd0);
                end
            end else if (i_valid) begin
                active = 1;
                cyc = 0;
                wcnt = 0;
            end else if (o_valid) begin
                check("stray_valid", 32'd1, 32'd0);
            end
        end
    end

    task automatic send(input logic [2:0] mode, input logic [15:0] data, input logic [2:0] lvl,
                        input logic od, input bit extra);
        exp_t x;
        x.data = data; x.fin = 1'b0; x.lat = 3; x.wcnt = 0; x.wcyc = 0;
        x.waddr = '0; x.wdata = '0; x.chk_raddr = 1'b0; x.raddr = '0;
        if (mode == 3'd3) begin
            if (m_prev != 3'd3) begin
                m_wr = 0;
                m_len = 0;
            end
            if (m_wr < int'(MAXL)) begin
                exp_mem[m_wr] = data;
                x.wcnt = 2; x.wcyc = 1;
                x.waddr = BASE + 20'(m_wr); x.wdata = data;
                x.chk_raddr = 1'b1; x.raddr = x.waddr;
                m_wr++;
                x.fin = (m_wr == int'(MAXL));
            end
        end else begin
            if (m_prev == 3'd3) begin
                m_len = m_wr;
                m_rd = 0;
            end
            if (mode == 3'd4 && m_len > 0) begin
                x.data = mix(data, exp_mem[m_rd], lvl);
                x.chk_raddr = 1'b1;
                x.raddr = BASE + 20'(m_rd);
`ifdef LOOPER_OVERDUB_EN
                if (od) begin
                    x.lat = 4; x.wcnt = 1; x.wcyc = 3;
                    x.waddr = x.raddr; x.wdata = x.data;
                    exp_mem[m_rd] = x.data;
                end
`endif
                m_rd = (m_rd == m_len - 1) ? 0 : m_rd + 1;
            end
        end
        m_prev = mode;
        sb.push_back(x);

        @(posedge clk); #1;
        i_mode = mode; i_data = data; i_level = lvl; i_overdub = od; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_mode = 3'($urandom); i_level = 3'($urandom);
        i_data = 16'($urandom); i_overdub = 1'($urandom);
        if (extra) begin
            @(posedge clk); #1 i_valid = 1'b1;
            @(posedge clk); #1 i_valid = 1'b0;
        end
        for (int n = 0; n < 12 && sb.size() != 0; n++) @(posedge clk);
        if (sb.size() != 0) begin
            check("timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_addr"}, 32'(sram_addr), 32'd0);
        check({pfx, "_we_n"}, 32'(sram_we_n), 32'd1);
        check({pfx, "_wdata"}, 32'(sram_wdata), 32'd0);
        check({pfx, "_data"}, 32'(o_data), 32'd0);
        check({pfx, "_valid"}, 32'(o_valid), 32'd0);
        check({pfx, "_fin"}, 32'(o_record_finish), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        rst_n = 1'b1;

        // Record three samples, then leave record
        send(3'd3, 16'd100, 3'd0, 1'b0, 1'b0);
        send(3'd3, 16'd200, 3'd0, 1'b0, 1'b1);
        send(3'd3, 16'd300, 3'd0, 1'b0, 1'b0);
        send(3'd0, 16'd7, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send(3'd4, 16'd0, 3'd0, 1'b0, 1'b0);
        send(3'd4, 16'd1000, 3'd7, 1'b0, 1'b0);
        send(3'd4, 16'hFFCE, 3'd2, 1'b0, 1'b0);
        send(3'd0, 16'h1234, 3'd0, 1'b0, 1'b0);

        // Saturation both ways and level scaling
        send(3'd3, 16'h7000, 3'd0, 1'b0, 1'b0);
        send(3'd4, 16'h7000, 3'd0, 1'b0, 1'b0);
        send(3'd3, 16'h8AD0, 3'd0, 1'b0, 1'b0);
        send(3'd4, 16'h8AD0, 3'd0, 1'b0, 1'b0);
        send(3'd3, 16'd800, 3'd0, 1'b0, 1'b0);
        send(3'd4, 16'd0, 3'd4, 1'b0, 1'b0);

        // Recording past MAX_LEN
        for (int i = 1; i <= 6; i++) send(3'd3, 16'(i), 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send(3'd4, 16'd0, 3'd0, 1'b0, 1'b0);

        // Overdub request (write-back only when the option is built in)
        send(3'd3, 16'd100, 3'd0, 1'b0, 1'b0);
        send(3'd4, 16'd50, 3'd0, 1'b1, 1'b0);
        send(3'd4, 16'd0, 3'd0, 1'b0, 1'b0);

        // Reset during cycle 1 of a write slot
        @(posedge clk); #1;
        i_mode = 3'd3; i_data = 16'd55; i_level = 3'd0; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        check("pre_rst_we_n", 32'(sram_we_n), 32'd0);
        rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        m_prev = 3'd0; m_wr = 0; m_len = 0; m_rd = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send(3'd4, 16'd9, 3'd0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
